// File: rtl/mips_exec_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS execution core: FSM states,
// instruction field types, opcode/function codes and the regfile
// write-address select values.
package codes;

    typedef logic [1:0]  state_t;
    typedef logic [5:0]  opcode_t;
    typedef logic [5:0]  func_t;
    typedef logic [4:0]  regimm_t;
    typedef logic [31:0] size_t;
    typedef logic [4:0]  regaddr_t;

    localparam state_t STATE_FETCH = 2'd0;
    localparam state_t STATE_EXEC  = 2'd1;
    localparam state_t STATE_HALT  = 2'd2;

    localparam logic REGFILE_ADDR_SEL_RD = 1'b0;
    localparam logic REGFILE_ADDR_SEL_RT = 1'b1;

    localparam opcode_t OP_SPECIAL = 6'h00;
    localparam opcode_t OP_REGIMM  = 6'h01;
    localparam opcode_t OP_J       = 6'h02;
    localparam opcode_t OP_JAL     = 6'h03;
    localparam opcode_t OP_BEQ     = 6'h04;
    localparam opcode_t OP_BNE     = 6'h05;
    localparam opcode_t OP_BLEZ    = 6'h06;
    localparam opcode_t OP_BGTZ    = 6'h07;
    localparam opcode_t OP_ADDIU   = 6'h09;
    localparam opcode_t OP_SLTI    = 6'h0A;
    localparam opcode_t OP_SLTIU   = 6'h0B;
    localparam opcode_t OP_ANDI    = 6'h0C;
    localparam opcode_t OP_ORI     = 6'h0D;
    localparam opcode_t OP_XORI    = 6'h0E;
    localparam opcode_t OP_LUI     = 6'h0F;
    localparam opcode_t OP_LW      = 6'h23;
    localparam opcode_t OP_SW      = 6'h2B;

    localparam func_t FUNC_SLL   = 6'h00;
    localparam func_t FUNC_SRL   = 6'h02;
    localparam func_t FUNC_SRA   = 6'h03;
    localparam func_t FUNC_SLLV  = 6'h04;
    localparam func_t FUNC_SRLV  = 6'h06;
    localparam func_t FUNC_SRAV  = 6'h07;
    localparam func_t FUNC_JR    = 6'h08;
    localparam func_t FUNC_JALR  = 6'h09;
    localparam func_t FUNC_MFHI  = 6'h10;
    localparam func_t FUNC_MTHI  = 6'h11;
    localparam func_t FUNC_MFLO  = 6'h12;
    localparam func_t FUNC_MTLO  = 6'h13;
    localparam func_t FUNC_MULT  = 6'h18;
    localparam func_t FUNC_MULTU = 6'h19;
    localparam func_t FUNC_DIV   = 6'h1A;
    localparam func_t FUNC_DIVU  = 6'h1B;
    localparam func_t FUNC_ADDU  = 6'h21;
    localparam func_t FUNC_SUBU  = 6'h23;
    localparam func_t FUNC_AND   = 6'h24;
    localparam func_t FUNC_OR    = 6'h25;
    localparam func_t FUNC_XOR   = 6'h26;
    localparam func_t FUNC_NOR   = 6'h27;
    localparam func_t FUNC_SLT   = 6'h2A;
    localparam func_t FUNC_SLTU  = 6'h2B;

    // Sign-extend a 16-bit immediate to a full word.
    function automatic size_t sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // Zero-extend a 16-bit immediate to a full word.
    function automatic size_t zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/mips_exec_ctrl_if.sv
// Avalon-side memory strobes of the execution core. The core is the
// master: it drives read/write/byte-enable/address-select and receives
// the zero-wait read data in the same cycle.
interface mips_exec_ctrl_if;

    logic        ram_read_en_o;
    logic        ram_write_en_o;
    logic [3:0]  ram_byte_en_o;
    logic        ram_addr_sel_o;
    logic [31:0] ram_readdata_i;

    modport master (
        output ram_read_en_o,
        output ram_write_en_o,
        output ram_byte_en_o,
        output ram_addr_sel_o,
        input  ram_readdata_i
    );

    modport slave (
        input  ram_read_en_o,
        input  ram_write_en_o,
        input  ram_byte_en_o,
        input  ram_addr_sel_o,
        output ram_readdata_i
    );

endinterface

// File: rtl/mips_exec_ctrl_alu_hilo.sv
// ALU for the execution core: combinational R-type and I-type results,
// effective address, and the HI/LO registers written by MULT/DIV/MTHI/MTLO.
module mips_alu_hilo
    import codes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hilo_write_en,
    input  opcode_t     opcode_i,
    input  func_t       funct_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [15:0] immediate_i,
    input  logic [31:0] ram_readdata_i,
    output logic [31:0] rd_o,
    output logic [31:0] rt_o,
    output logic [31:0] effective_address_o,
    output logic [31:0] mfhi_o,
    output logic [31:0] mflo_o
);

    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;
    logic signed [31:0] imm_s;
    logic        [31:0] imm_sext;
    logic        [31:0] imm_zext;
    logic        [4:0]  shamt;
    logic        [4:0]  shamt_v;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    logic [31:0] hi_q;
    logic [31:0] lo_q;

    assign rs_s     = $signed(rs_i);
    assign rt_s     = $signed(rt_i);
    assign imm_sext = sext16(immediate_i);
    assign imm_zext = zext16(immediate_i);
    assign imm_s    = $signed(imm_sext);
    assign shamt    = immediate_i[10:6];
    assign shamt_v  = rs_i[4:0];

    assign effective_address_o = rs_i + imm_sext;

    // Operands are widened explicitly so the product keeps all 64 bits.
    assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    assign prod_u = {32'h0, rs_i} * {32'h0, rt_i};
    // Division results are only consumed when the divisor is non-zero.
    assign quot_s = rs_s / rt_s;
    assign rem_s  = rs_s % rt_s;
    assign quot_u = rs_i / rt_i;
    assign rem_u  = rs_i % rt_i;

    // R-type result selected by the function field; non-ALU functions give 0.
    always_comb begin
        rd_o = 32'h0;
        if (opcode_i == OP_SPECIAL) begin
            case (funct_i)
                FUNC_ADDU: rd_o = rs_i + rt_i;
                FUNC_SUBU: rd_o = rs_i - rt_i;
                FUNC_AND:  rd_o = rs_i & rt_i;
                FUNC_OR:   rd_o = rs_i | rt_i;
                FUNC_XOR:  rd_o = rs_i ^ rt_i;
                FUNC_NOR:  rd_o = ~(rs_i | rt_i);
                FUNC_SLT:  rd_o = {31'h0, (rs_s < rt_s)};
                FUNC_SLTU: rd_o = {31'h0, (rs_i < rt_i)};
                FUNC_SLL:  rd_o = rt_i << shamt;
                FUNC_SRL:  rd_o = rt_i >> shamt;
                FUNC_SRA:  rd_o = $unsigned(rt_s >>> shamt);
                FUNC_SLLV: rd_o = rt_i << shamt_v;
                FUNC_SRLV: rd_o = rt_i >> shamt_v;
                FUNC_SRAV: rd_o = $unsigned(rt_s >>> shamt_v);
                default:   rd_o = 32'h0;
            endcase
        end
    end

    // I-type result; for SW this carries the store data.
    always_comb begin
        case (opcode_i)
            OP_ADDIU: rt_o = rs_i + imm_sext;
            OP_SLTI:  rt_o = {31'h0, (rs_s < imm_s)};
            OP_SLTIU: rt_o = {31'h0, (rs_i < imm_sext)};
            OP_ANDI:  rt_o = rs_i & imm_zext;
            OP_ORI:   rt_o = rs_i | imm_zext;
            OP_XORI:  rt_o = rs_i ^ imm_zext;
            OP_LUI:   rt_o = {immediate_i, 16'h0000};
            OP_LW:    rt_o = ram_readdata_i;
            OP_SW:    rt_o = rt_i;
            default:  rt_o = 32'h0;
        endcase
    end

    // HI/LO update at the end of an unstalled EXEC cycle; reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else if (hilo_write_en && opcode_i == OP_SPECIAL) begin
            case (funct_i)
                FUNC_MULT: begin
                    hi_q <= prod_s[63:32];
                    lo_q <= prod_s[31:0];
                end
                FUNC_MULTU: begin
                    hi_q <= prod_u[63:32];
                    lo_q <= prod_u[31:0];
                end
                FUNC_DIV: begin
                    if (rt_i != 32'h0) begin
                        hi_q <= $unsigned(rem_s);
                        lo_q <= $unsigned(quot_s);
                    end
                end
                FUNC_DIVU: begin
                    if (rt_i != 32'h0) begin
                        hi_q <= rem_u;
                        lo_q <= quot_u;
                    end
                end
                FUNC_MTHI: hi_q <= rs_i;
                FUNC_MTLO: lo_q <= rs_i;
                default: ;
            endcase
        end
    end

    assign mfhi_o = hi_q;
    assign mflo_o = lo_q;

endmodule

// File: rtl/mips_exec_ctrl.sv
// Multi-cycle execution core: FETCH/EXEC/HALT state machine, control
// decode for memory, PC, IR and register-file enables, and the ALU/HI/LO
// sub-module. All control outputs are combinational from state and inputs.
module mips_exec_ctrl
    import codes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        halt_i,
    input  logic        stall_i,
    input  opcode_t     opcode_i,
    input  func_t       funct_i,
    input  regimm_t     regimm_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [15:0] immediate_i,
    input  logic [25:0] target_i,
    input  logic [31:0] pc_i,
    mips_exec_ctrl_if.master bus,
    output state_t      state_o,
    output logic        pc_write_en_o,
    output logic        ir_write_en_o,
    output logic        regfile_write_en_o,
    output logic        src_b_sel_o,
    output logic        regfile_addr_3_sel_o,
    output logic [31:0] rd_o,
    output logic [31:0] rt_o,
    output logic [31:0] effective_address_o,
    output logic        b_cond_met_o,
    output logic [31:0] mfhi_o,
    output logic [31:0] mflo_o
);

    state_t state_q;
    logic   is_rtype;
    logic   is_itype_alu;
    logic   rtype_writes_rd;
    logic   read_en;
    logic   write_en;
    logic   hilo_write_en;

    // Reserved fields: branches/jumps other than JR are handled elsewhere.
    logic unused_fields;
    assign unused_fields = ^{regimm_i, target_i, pc_i};

    // State register: halt sampled only in FETCH, HALT sticky, stall freezes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_FETCH;
        end else if (!stall_i) begin
            case (state_q)
                STATE_FETCH: state_q <= halt_i ? STATE_HALT : STATE_EXEC;
                STATE_EXEC:  state_q <= STATE_FETCH;
                STATE_HALT:  state_q <= STATE_HALT;
                default:     state_q <= STATE_FETCH;
            endcase
        end
    end

    assign state_o = state_q;

    assign is_rtype = (opcode_i == OP_SPECIAL);

    // Instruction-class decode used by the enable logic.
    always_comb begin
        is_itype_alu = 1'b0;
        case (opcode_i)
            OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: is_itype_alu = 1'b1;
            default: is_itype_alu = 1'b0;
        endcase

        rtype_writes_rd = is_rtype;
        case (funct_i)
            FUNC_JR, FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU,
            FUNC_MTHI, FUNC_MTLO: rtype_writes_rd = 1'b0;
            default: ;
        endcase
    end

    // Per-state control enables.
    always_comb begin
        read_en              = 1'b0;
        write_en             = 1'b0;
        pc_write_en_o        = 1'b0;
        ir_write_en_o        = 1'b0;
        regfile_write_en_o   = 1'b0;
        src_b_sel_o          = 1'b0;
        regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RD;
        bus.ram_addr_sel_o   = 1'b0;
        b_cond_met_o         = 1'b0;
        case (state_q)
            STATE_FETCH: begin
                read_en       = 1'b1;
                ir_write_en_o = 1'b1;
            end
            STATE_EXEC: begin
                pc_write_en_o = 1'b1;
                b_cond_met_o  = is_rtype && (funct_i == FUNC_JR);
                if (opcode_i == OP_LW) begin
                    read_en              = 1'b1;
                    bus.ram_addr_sel_o   = 1'b1;
                    regfile_write_en_o   = 1'b1;
                    regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RT;
                end else if (opcode_i == OP_SW) begin
                    write_en           = 1'b1;
                    bus.ram_addr_sel_o = 1'b1;
                end else if (is_itype_alu) begin
                    regfile_write_en_o   = 1'b1;
                    regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RT;
                    src_b_sel_o          = 1'b1;
                end else if (rtype_writes_rd) begin
                    regfile_write_en_o   = 1'b1;
                    regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RD;
                end
            end
            default: ;
        endcase
    end

    assign bus.ram_read_en_o  = read_en;
    assign bus.ram_write_en_o = write_en;
    assign bus.ram_byte_en_o  = (read_en || write_en) ? 4'b1111 : 4'b0000;

    assign hilo_write_en = (state_q == STATE_EXEC) && !stall_i;

    mips_alu_hilo u_alu_hilo (
        .clk                 (clk),
        .reset               (reset),
        .hilo_write_en       (hilo_write_en),
        .opcode_i            (opcode_i),
        .funct_i             (funct_i),
        .rs_i                (rs_i),
        .rt_i                (rt_i),
        .immediate_i         (immediate_i),
        .ram_readdata_i      (bus.ram_readdata_i),
        .rd_o                (rd_o),
        .rt_o                (rt_o),
        .effective_address_o (effective_address_o),
        .mfhi_o              (mfhi_o),
        .mflo_o              (mflo_o)
    );

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed testbench for mips_exec_ctrl: fetch/exec/halt sequencing,
// ALU results, HI/LO behaviour, memory strobes and JR.
module tb_mips_exec_ctrl;
    import codes::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt_i;
    logic        stall_i;
    opcode_t     opcode_i;
    func_t       funct_i;
    regimm_t     regimm_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic [15:0] immediate_i;
    logic [25:0] target_i;
    logic [31:0] pc_i;
    state_t      state_o;
    logic        pc_write_en_o, ir_write_en_o, regfile_write_en_o;
    logic        src_b_sel_o, regfile_addr_3_sel_o, b_cond_met_o;
    logic [31:0] rd_o, rt_o, effective_address_o, mfhi_o, mflo_o;

    int total = 0;
    int bad   = 0;

    mips_exec_ctrl_if bus();

    mips_exec_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .halt_i               (halt_i),
        .stall_i              (stall_i),
        .opcode_i             (opcode_i),
        .funct_i              (funct_i),
        .regimm_i             (regimm_i),
        .rs_i                 (rs_i),
        .rt_i                 (rt_i),
        .immediate_i          (immediate_i),
        .target_i             (target_i),
        .pc_i                 (pc_i),
        .bus                  (bus.master),
        .state_o              (state_o),
        .pc_write_en_o        (pc_write_en_o),
        .ir_write_en_o        (ir_write_en_o),
        .regfile_write_en_o   (regfile_write_en_o),
        .src_b_sel_o          (src_b_sel_o),
        .regfile_addr_3_sel_o (regfile_addr_3_sel_o),
        .rd_o                 (rd_o),
        .rt_o                 (rt_o),
        .effective_address_o  (effective_address_o),
        .b_cond_met_o         (b_cond_met_o),
        .mfhi_o               (mfhi_o),
        .mflo_o               (mflo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input opcode_t op, input func_t fn, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [15:0] imm);
        opcode_i    = op;
        funct_i     = fn;
        rs_i        = rs;
        rt_i        = rt;
        immediate_i = imm;
    endtask

    initial begin
        reset = 1'b1; halt_i = 1'b0; stall_i = 1'b0;
        regimm_i = '0; target_i = '0; pc_i = 32'h1;
        bus.ram_readdata_i = 32'h0;
        set_instr(OP_SPECIAL, FUNC_SLL, 32'h0, 32'h0, 16'h0);
        step(); step();
        check("rst_state", 32'(state_o), 32'(STATE_FETCH));
        check("rst_hi", mfhi_o, 32'h0);
        check("rst_lo", mflo_o, 32'h0);

        reset = 1'b0;
        #1;
        check("fetch_state", 32'(state_o), 0);
        check("fetch_read", 32'(bus.ram_read_en_o), 1);
        check("fetch_irwe", 32'(ir_write_en_o), 1);
        check("fetch_be", 32'(bus.ram_byte_en_o), 32'hF);
        check("fetch_pcwe", 32'(pc_write_en_o), 0);
        check("fetch_asel", 32'(bus.ram_addr_sel_o), 0);
        check("fetch_rfwe", 32'(regfile_write_en_o), 0);

        // ADDIU
        set_instr(OP_ADDIU, 6'h0, 32'hFFFF_FFFF, 32'h0, 16'h0002);
        step();
        check("exec_state", 32'(state_o), 1);
        check("exec_pcwe", 32'(pc_write_en_o), 1);
        check("exec_irwe", 32'(ir_write_en_o), 0);
        check("exec_read", 32'(bus.ram_read_en_o), 0);
        check("exec_be", 32'(bus.ram_byte_en_o), 0);
        check("addiu_rt", rt_o, 32'h1);
        check("addiu_rfwe", 32'(regfile_write_en_o), 1);
        check("addiu_a3", 32'(regfile_addr_3_sel_o), 1);
        check("addiu_srcb", 32'(src_b_sel_o), 1);
        // other I-type results evaluated combinationally in EXEC
        set_instr(OP_LUI, 6'h0, 32'h0, 32'h0, 16'h1234);
        #1 check("lui_rt", rt_o, 32'h1234_0000);
        set_instr(OP_ORI, 6'h0, 32'h0000_0001, 32'h0, 16'h8000);
        #1 check("ori_rt", rt_o, 32'h0000_8001);
        set_instr(OP_SLTIU, 6'h0, 32'h0000_0005, 32'h0, 16'hFFFF);
        #1 check("sltiu_rt", rt_o, 32'h1);
        set_instr(OP_SLTI, 6'h0, 32'h0000_0005, 32'h0, 16'hFFFF);
        #1 check("slti_rt", rt_o, 32'h0);
        step();
        check("back_fetch", 32'(state_o), 0);

        // SLT / SLTU / shifts
        set_instr(OP_SPECIAL, FUNC_SLT, 32'h8000_0000, 32'h1, 16'h0);
        step();
        check("slt_rd", rd_o, 32'h1);
        check("slt_rfwe", 32'(regfile_write_en_o), 1);
        check("slt_a3", 32'(regfile_addr_3_sel_o), 0);
        check("slt_srcb", 32'(src_b_sel_o), 0);
        funct_i = FUNC_SLTU;
        #1 check("sltu_rd", rd_o, 32'h0);
        set_instr(OP_SPECIAL, FUNC_SLL, 32'h0, 32'h1, 16'h0100);
        #1 check("sll_rd", rd_o, 32'h10);
        set_instr(OP_SPECIAL, FUNC_SRAV, 32'h4, 32'h8000_0000, 16'h0);
        #1 check("srav_rd", rd_o, 32'hF800_0000);
        set_instr(OP_SPECIAL, FUNC_SUBU, 32'h0, 32'h1, 16'h0);
        #1 check("subu_rd", rd_o, 32'hFFFF_FFFF);
        set_instr(OP_SPECIAL, FUNC_MFHI, 32'h5, 32'h6, 16'h0);
        #1 check("mfhi_rd", rd_o, 32'h0);
        check("mfhi_rfwe", 32'(regfile_write_en_o), 1);
        step();

        // MULT
        set_instr(OP_SPECIAL, FUNC_MULT, 32'hFFFF_FFFE, 32'h3, 16'h0);
        step();
        check("mult_rfwe", 32'(regfile_write_en_o), 0);
        check("mult_hi_pre", mfhi_o, 32'h0);
        step();
        check("mult_hi", mfhi_o, 32'hFFFF_FFFF);
        check("mult_lo", mflo_o, 32'hFFFF_FFFA);

        // DIVU by zero leaves HI/LO
        set_instr(OP_SPECIAL, FUNC_DIVU, 32'h5, 32'h0, 16'h0);
        step(); step();
        check("divu0_hi", mfhi_o, 32'hFFFF_FFFF);
        check("divu0_lo", mflo_o, 32'hFFFF_FFFA);

        // DIV signed, truncating toward zero: -7 / 2 = -3 rem -1
        set_instr(OP_SPECIAL, FUNC_DIV, 32'hFFFF_FFF9, 32'h2, 16'h0);
        step(); step();
        check("div_hi", mfhi_o, 32'hFFFF_FFFF);
        check("div_lo", mflo_o, 32'hFFFF_FFFD);

        // MULTU
        set_instr(OP_SPECIAL, FUNC_MULTU, 32'hFFFF_FFFF, 32'h2, 16'h0);
        step(); step();
        check("multu_hi", mfhi_o, 32'h1);
        check("multu_lo", mflo_o, 32'hFFFF_FFFE);

        // Stall in FETCH and in EXEC (MTLO held off)
        stall_i = 1'b1;
        step();
        check("stall_fetch", 32'(state_o), 0);
        stall_i = 1'b0;
        set_instr(OP_SPECIAL, FUNC_MTLO, 32'h0000_1234, 32'h0, 16'h0);
        step();
        stall_i = 1'b1;
        step();
        check("stall_exec", 32'(state_o), 1);
        check("stall_lo", mflo_o, 32'hFFFF_FFFE);
        stall_i = 1'b0;
        step();
        check("mtlo_state", 32'(state_o), 0);
        check("mtlo_lo", mflo_o, 32'h0000_1234);

        // LW
        set_instr(OP_LW, 6'h0, 32'h0000_1000, 32'h0, 16'hFFFC);
        bus.ram_readdata_i = 32'hDEAD_BEEF;
        step();
        check("lw_ea", effective_address_o, 32'h0000_0FFC);
        check("lw_read", 32'(bus.ram_read_en_o), 1);
        check("lw_asel", 32'(bus.ram_addr_sel_o), 1);
        check("lw_be", 32'(bus.ram_byte_en_o), 32'hF);
        check("lw_rt", rt_o, 32'hDEAD_BEEF);
        check("lw_rfwe", 32'(regfile_write_en_o), 1);
        check("lw_a3", 32'(regfile_addr_3_sel_o), 1);
        step();

        // SW
        set_instr(OP_SW, 6'h0, 32'h0000_2000, 32'hCAFE_F00D, 16'h0004);
        step();
        check("sw_write", 32'(bus.ram_write_en_o), 1);
        check("sw_read", 32'(bus.ram_read_en_o), 0);
        check("sw_be", 32'(bus.ram_byte_en_o), 32'hF);
        check("sw_asel", 32'(bus.ram_addr_sel_o), 1);
        check("sw_rt", rt_o, 32'hCAFE_F00D);
        check("sw_ea", effective_address_o, 32'h0000_2004);
        check("sw_rfwe", 32'(regfile_write_en_o), 0);
        step();

        // JR
        set_instr(OP_SPECIAL, FUNC_JR, 32'h0000_0040, 32'h0, 16'h0);
        check("jr_fetch_bcond", 32'(b_cond_met_o), 0);
        step();
        check("jr_bcond", 32'(b_cond_met_o), 1);
        check("jr_rfwe", 32'(regfile_write_en_o), 0);
        check("jr_pcwe", 32'(pc_write_en_o), 1);
        step();

        // halt_i ignored in EXEC
        set_instr(OP_SPECIAL, FUNC_ADDU, 32'h1, 32'h2, 16'h0);
        step();
        check("addu_rd", rd_o, 32'h3);
        halt_i = 1'b1;
        step();
        check("halt_in_exec", 32'(state_o), 0);

        // halt_i in FETCH -> HALT, sticky through stall toggles
        step();
        check("halt_state", 32'(state_o), 2);
        check("halt_read", 32'(bus.ram_read_en_o), 0);
        check("halt_irwe", 32'(ir_write_en_o), 0);
        check("halt_pcwe", 32'(pc_write_en_o), 0);
        check("halt_rfwe", 32'(regfile_write_en_o), 0);
        check("halt_be", 32'(bus.ram_byte_en_o), 0);
        halt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stall_i = i[0];
            step();
            check("halt_sticky", 32'(state_o), 2);
        end
        stall_i = 1'b0;

        // Reset mid-EXEC: back to FETCH, no HI/LO write
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_instr(OP_SPECIAL, FUNC_MTHI, 32'h0000_AAAA, 32'h0, 16'h0);
        step();
        check("pre_rst_exec", 32'(state_o), 1);
        reset = 1'b1;
        step();
        check("rst_exec_state", 32'(state_o), 0);
        check("rst_exec_hi", mfhi_o, 32'h0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
